// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, state/encoding enums and the decoded control bus for multicycle_control
package ctrl_pkg;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_BR  = 2'b01,
    ALU_R   = 2'b10,
    ALU_I   = 2'b11
  } alu_op_t;
  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_RS1   = 2'b10
  } pc_src_t;
  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_TIMEOUT = 2'b10
  } trap_cause_t;
  typedef struct packed {
    logic    alu_src;
    logic    mem_to_reg;
    logic    uncond_jump;
    logic    auipc;
    logic    imm_unsigned;
    alu_op_t alu_op;
    logic    is_load;
    logic    is_store;
    logic    is_branch;
    logic    is_jalr;
    logic    is_legal;
  } ctrl_bus_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: unified valid/ready memory port between the controller and memory
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic i_sel;
  logic mem_ready;
  modport master (output mem_req, mem_we, i_sel, input mem_ready);
  modport slave  (input mem_req, mem_we, i_sel, output mem_ready);
endinterface

// File: rtl/opcode_decoder.sv
// opcode_decoder: combinational RV32I opcode to control-bus decode
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_bus_t  ctrl
);
  // unknown opcodes fall through to an all-zero bus with is_legal cleared
  always_comb begin
    ctrl = '0;
    ctrl.is_legal = 1'b1;
    case (opcode)
      OP_BTYPE: begin ctrl.alu_op = ALU_BR; ctrl.is_branch = 1'b1; end
      OP_RTYPE: ctrl.alu_op = ALU_R;
      OP_STORE: begin ctrl.alu_src = 1'b1; ctrl.is_store = 1'b1; end
      OP_LOAD:  begin ctrl.alu_src = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.is_load = 1'b1; end
      OP_ITYPE: begin ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_I; end
      OP_JAL:   ctrl.uncond_jump = 1'b1;
      OP_JALR:  begin ctrl.alu_src = 1'b1; ctrl.uncond_jump = 1'b1; ctrl.is_jalr = 1'b1; end
      OP_LUI:   begin ctrl.alu_src = 1'b1; ctrl.imm_unsigned = 1'b1; end
      OP_AUIPC: begin ctrl.alu_src = 1'b1; ctrl.imm_unsigned = 1'b1; ctrl.auipc = 1'b1; end
      default:  ctrl.is_legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and sticky trap; ILLEGAL_TRAP_EN traps unknown opcodes (else NOP)
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W       = 7,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 br_taken,
  multicycle_control_if.master mem,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 reg_we,
  output logic                 alu_src,
  output logic                 mem_to_reg,
  output logic                 uncond_jump,
  output logic                 auipc,
  output logic                 imm_unsigned,
  output logic [1:0]           alu_op,
  output logic                 retire,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [1:0]           trap_cause
);
  localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT_CYCLES);
  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  trap_cause_t cause_q, cause_d;
  ctrl_bus_t   ctrl_q, ctrl_d, dec;
  logic [CNT_W-1:0] cnt_q;
  logic        rst_seen_q;
  logic        req, done, timeout;
  pc_src_t     src;

  opcode_decoder u_dec (.opcode(opcode), .ctrl(dec));

  // the request is held off while in reset and for one cycle after, so an aborted handshake is not re-issued immediately
  assign req     = (state_q == FETCH || state_q == MEM) && !rst && !rst_seen_q;
  assign done    = req && mem.mem_ready;
  assign timeout = req && !mem.mem_ready && (wait_q + 8'd1 == WAIT_LIM);

  // state register, wait counter, trap cause, registered control bus and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      wait_q  <= '0;
      cause_q <= TC_NONE;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_q + CNT_W'(retire);
    end
    rst_seen_q <= rst;
  end

  // next-state, trap cause and decode capture
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      FETCH:  state_d = done ? DECODE : timeout ? TRAP : FETCH;
`ifdef ILLEGAL_TRAP_EN
      DECODE: begin
        ctrl_d  = dec;
        state_d = dec.is_legal ? EXEC : TRAP;
        cause_d = dec.is_legal ? cause_q : TC_ILLEGAL;
      end
`else
      DECODE: begin
        ctrl_d  = dec;
        state_d = EXEC;
      end
`endif
      EXEC:   state_d = ctrl_q.is_branch ? FETCH : (ctrl_q.is_load || ctrl_q.is_store) ? MEM : WB;
      MEM:    state_d = done ? (ctrl_q.is_load ? WB : FETCH) : timeout ? TRAP : MEM;
      WB:     state_d = FETCH;
      default: state_d = TRAP;
    endcase
    if (timeout) cause_d = TC_TIMEOUT;
    wait_d = (state_d != state_q || done || !req) ? 8'd0 : wait_q + 8'd1;
  end

  // state-gated strobes; unknown opcodes reaching WB write no register
  always_comb begin
    ir_we  = 1'b0;
    pc_we  = 1'b0;
    reg_we = 1'b0;
    retire = 1'b0;
    src    = PC_PLUS4;
    case (state_q)
      FETCH: ir_we = done;
      EXEC: if (ctrl_q.is_branch) begin
        pc_we  = 1'b1;
        retire = 1'b1;
        src    = br_taken ? PC_IMM : PC_PLUS4;
      end
      MEM: if (done && ctrl_q.is_store) begin
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      WB: begin
        reg_we = ctrl_q.is_legal;
        pc_we  = 1'b1;
        retire = 1'b1;
        src    = ctrl_q.is_jalr ? PC_RS1 : ctrl_q.uncond_jump ? PC_IMM : PC_PLUS4;
      end
      default: ;
    endcase
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = req && state_q == MEM && ctrl_q.is_store;
  assign mem.i_sel     = state_q == FETCH;
  assign pc_src        = src;
  assign alu_src       = ctrl_q.alu_src;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign uncond_jump   = ctrl_q.uncond_jump;
  assign auipc         = ctrl_q.auipc;
  assign imm_unsigned  = ctrl_q.imm_unsigned;
  assign alu_op        = ctrl_q.alu_op;
  assign retired_cnt   = cnt_q;
  assign state         = state_q;
  assign halted        = state_q == TRAP;
  assign trap_cause    = cause_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven, directed and randomized checks of multicycle_control against a per-instruction model
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = '0;
  logic br_taken = 1'b0;
  logic ir_we, pc_we, reg_we, retire, halted;
  logic alu_src, mem_to_reg, uncond_jump, auipc, imm_unsigned;
  logic [1:0] pc_src, alu_op, trap_cause;
  logic [31:0] retired_cnt;
  logic [2:0] state;
  int pass_n = 0;
  int total_n = 0;
  int exp_cnt = 0;

  multicycle_control_if mif ();

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem(mif),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .uncond_jump(uncond_jump),
    .auipc(auipc), .imm_unsigned(imm_unsigned), .alu_op(alu_op),
    .retire(retire), .retired_cnt(retired_cnt), .state(state),
    .halted(halted), .trap_cause(trap_cause)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic       br;
    int         wf;
    int         wm;
    int         cpi;
    int         regw;
    logic [1:0] src;
    logic [6:0] dbits;
  } vec_t;

  typedef struct {
    int cyc, reg_n, pc_n, ir_n, ret_n, req_n, we_n, dreq_n;
    logic [1:0]  src;
    logic [6:0]  dbits;
    logic [31:0] cnt0;
    logic        trap;
  } res_t;

  typedef struct {
    int cpi, regw, req, we, dreq;
    logic [1:0] src;
  } exp_t;

  logic [6:0] legal_ops [9] = '{7'b1100011, 7'b0110011, 7'b0100011, 7'b0000011,
                                7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  task automatic chk(string t, string f, longint act, longint exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s.%s: got %0d expected %0d", t, f, act, exp);
  endtask

  function automatic bit is_legal(logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // expected per-instruction totals straight from the CPI / strobe rules
  function automatic exp_t model(logic [6:0] op, logic br, int wf, int wm);
    exp_t e;
    bit ld = op == 7'b0000011;
    bit st = op == 7'b0100011;
    bit bt = op == 7'b1100011;
    int mw = (ld || st) ? wm + 1 : 0;
    e.cpi  = (bt ? 3 : ld ? 5 : 4) + wf + ((ld || st) ? wm : 0);
    e.regw = (is_legal(op) && !bt && !st) ? 1 : 0;
    e.req  = wf + 1 + mw;
    e.we   = st ? mw : 0;
    e.dreq = mw;
    e.src  = bt ? {1'b0, br} : op == 7'b1101111 ? 2'd1 : op == 7'b1100111 ? 2'd2 : 2'd0;
    return e;
  endfunction

  // memory answers after wf fetch / wm data wait cycles; idle-cycle ready is random noise
  task automatic run(input logic [6:0] op, input logic br, input int wf, input int wm, output res_t r);
    int cw;
    bit fin;
    r = '{default: 0};
    cw = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      opcode = op;
      br_taken = br;
      if (mif.mem_req) begin
        mif.mem_ready = cw >= (mif.i_sel ? wf : wm);
        cw = mif.mem_ready ? 0 : cw + 1;
      end else mif.mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (r.cyc == 0) r.cnt0 = retired_cnt;
      r.cyc++;
      r.reg_n += int'(reg_we);
      r.pc_n += int'(pc_we);
      r.ir_n += int'(ir_we);
      r.ret_n += int'(retire);
      r.req_n += int'(mif.mem_req);
      r.we_n += int'(mif.mem_we);
      r.dreq_n += int'(mif.mem_req && !mif.i_sel);
      if (pc_we) r.src = pc_src;
      if (retire) r.dbits = {alu_src, mem_to_reg, uncond_jump, auipc, imm_unsigned, alu_op};
      fin = retire || halted || r.cyc > 300;
    end
    r.trap = halted;
  endtask

  task automatic verify(string t, res_t r, exp_t e);
    chk(t, "cpi", r.cyc, e.cpi);
    chk(t, "reg_we", r.reg_n, e.regw);
    chk(t, "pc_src", r.src, e.src);
    chk(t, "mem_req", r.req_n, e.req);
    chk(t, "mem_we", r.we_n, e.we);
    chk(t, "data_req", r.dreq_n, e.dreq);
    chk(t, "pc_we", r.pc_n, 1);
    chk(t, "ir_we", r.ir_n, 1);
    chk(t, "retire", r.ret_n, 1);
    chk(t, "retired_cnt", r.cnt0, exp_cnt);
    chk(t, "trap", r.trap, 0);
    exp_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    chk("reset", "state", state, 0);
    chk("reset", "mem_req", mif.mem_req, 0);
    chk("reset", "retired_cnt", retired_cnt, 0);
    chk("reset", "halted", halted, 0);
    chk("reset", "trap_cause", trap_cause, 0);
    chk("reset", "decode_bits", {alu_src, mem_to_reg, uncond_jump, auipc, imm_unsigned, alu_op}, 0);
    rst = 1'b0;
    #1;
    chk("reset", "mem_req_after", mif.mem_req, 0);
    exp_cnt = 0;
  endtask

  initial begin
    vec_t tbl[$];
    res_t r;
    exp_t e;
    mif.mem_ready = 1'b0;
    tbl.push_back('{7'b0110011, 1'b0, 0, 0, 4, 1, 2'd0, 7'b0000010});
    tbl.push_back('{7'b0000011, 1'b0, 0, 3, 8, 1, 2'd0, 7'b1100000});
    tbl.push_back('{7'b1100011, 1'b1, 0, 0, 3, 0, 2'd1, 7'b0000001});
    tbl.push_back('{7'b1100011, 1'b0, 0, 0, 3, 0, 2'd0, 7'b0000001});
    tbl.push_back('{7'b0100011, 1'b0, 1, 2, 7, 0, 2'd0, 7'b1000000});
    tbl.push_back('{7'b0010011, 1'b0, 2, 0, 6, 1, 2'd0, 7'b1000011});
    tbl.push_back('{7'b1101111, 1'b0, 0, 0, 4, 1, 2'd1, 7'b0010000});
    tbl.push_back('{7'b1100111, 1'b0, 0, 0, 4, 1, 2'd2, 7'b1010000});
    tbl.push_back('{7'b0110111, 1'b0, 0, 0, 4, 1, 2'd0, 7'b1000100});
    tbl.push_back('{7'b0010111, 1'b0, 0, 0, 4, 1, 2'd0, 7'b1001100});
    tbl.push_back('{7'b0110011, 1'b0, 15, 0, 19, 1, 2'd0, 7'b0000010});
`ifndef ILLEGAL_TRAP_EN
    tbl.push_back('{7'b1111111, 1'b1, 0, 0, 4, 0, 2'd0, 7'b0000000});
`endif
    repeat (3) @(posedge clk);
    do_reset();

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      run(tbl[i].op, tbl[i].br, tbl[i].wf, tbl[i].wm, r);
      e = model(tbl[i].op, tbl[i].br, tbl[i].wf, tbl[i].wm);
      e.cpi = tbl[i].cpi;
      e.regw = tbl[i].regw;
      e.src = tbl[i].src;
      verify(t, r, e);
      chk(t, "decode_bits", r.dbits, tbl[i].dbits);
    end

`ifdef ILLEGAL_TRAP_EN
    run(7'b1111111, 1'b0, 0, 0, r);
    chk("illegal", "trap", r.trap, 1);
    chk("illegal", "cycles", r.cyc, 3);
    chk("illegal", "retire", r.ret_n, 0);
    chk("illegal", "trap_cause", trap_cause, 1);
    do_reset();
`endif

    for (int i = 0; i < 40; i++) begin
      logic [6:0] op;
      logic br;
      int wf, wm, k;
      k = int'($urandom_range(0, 9));
`ifdef ILLEGAL_TRAP_EN
      op = legal_ops[k % 9];
`else
      op = (k == 9) ? 7'($urandom) : legal_ops[k];
`endif
      br = 1'($urandom_range(0, 1));
      wf = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      wm = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      run(op, br, wf, wm, r);
      verify($sformatf("rnd%0d", i), r, model(op, br, wf, wm));
    end

    // reset pulse while a load waits in MEM
    @(negedge clk);
    opcode = 7'b0000011;
    mif.mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      mif.mem_ready = 1'b0;
    end
    #1;
    chk("rst_mem", "state_mem", state, 3);
    chk("rst_mem", "data_req", mif.mem_req && !mif.i_sel, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mem", "state", state, 0);
    chk("rst_mem", "mem_req", mif.mem_req, 0);
    chk("rst_mem", "retired_cnt", retired_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem", "fetch_resumes", {mif.mem_req, mif.i_sel}, 3);
    exp_cnt = 0;
    run(7'b0110011, 1'b0, 0, 0, r);
    verify("rst_mem_add", r, model(7'b0110011, 1'b0, 0, 0));

    // fetch timeout and sticky trap
    run(7'b0110011, 1'b0, 16, 0, r);
    chk("to_fetch", "trap", r.trap, 1);
    chk("to_fetch", "cycles", r.cyc, 17);
    chk("to_fetch", "mem_req", r.req_n, 16);
    chk("to_fetch", "ir_we", r.ir_n, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mif.mem_ready = 1'b1;
      #1;
      chk("to_fetch", "held_req", mif.mem_req, 0);
      chk("to_fetch", "held_halt", halted, 1);
      chk("to_fetch", "held_cause", trap_cause, 2);
      chk("to_fetch", "held_strobes", {ir_we, pc_we, reg_we, retire}, 0);
    end
    do_reset();

    // data-phase timeout
    run(7'b0000011, 1'b0, 0, 16, r);
    chk("to_mem", "trap", r.trap, 1);
    chk("to_mem", "cycles", r.cyc, 20);
    chk("to_mem", "data_req", r.dreq_n, 16);
    chk("to_mem", "trap_cause", trap_cause, 2);
    do_reset();

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
